// File: rtl/pa_pkg.sv
// Shared definitions for the pipelined Kogge-Stone adder.
//   gp_t        : per-bit (generate, propagate) pair carried through the prefix tree.
//   clog2       : ceiling log2, used for the number of prefix levels.
//   num_stages  : number of prefix register stages (NP) for a width / levels-per-stage pair.
//   latency     : accept-to-result latency in cycles (NP + 2).
package pa_pkg;

    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        int unsigned v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v << 1;
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int unsigned num_stages(input int unsigned width,
                                               input int unsigned lps);
        int unsigned l;
        l = clog2(width);
        return (l + lps - 1) / lps;
    endfunction

    // Stage G register + NP prefix registers + output register.
    function automatic int unsigned latency(input int unsigned width,
                                            input int unsigned lps);
        return num_stages(width, lps) + 2;
    endfunction

endpackage

// File: rtl/prefix_level.sv
// One Kogge-Stone prefix level, purely combinational.
//   gp_i : (g, p) per bit entering the level
//   gp_o : (g, p) per bit after combining bit i with bit i - DIST
// Bits below DIST have no partner at this distance and pass through unchanged.
module prefix_level
    import pa_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DIST       = 1
) (
    input  gp_t [DATA_WIDTH-1:0] gp_i,
    output gp_t [DATA_WIDTH-1:0] gp_o
);

    for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_bit
        if (i >= DIST) begin : g_comb
            assign gp_o[i].g = gp_i[i].g | (gp_i[i].p & gp_i[i - DIST].g);
            assign gp_o[i].p = gp_i[i].p & gp_i[i - DIST].p;
        end else begin : g_pass
            assign gp_o[i] = gp_i[i];
        end
    end

endmodule

// File: rtl/pipelined_prefix_adder.sv
// Pipelined Kogge-Stone adder/subtractor with valid/ready on both sides.
//   clk, rst_n              : clock, asynchronous active-low reset
//   in_valid_i / in_ready_o : operand beat handshake (in_ready_o is the global advance)
//   a_i, b_i                : operands
//   cin_i                   : carry-in, ignored when sub_i = 1
//   sub_i                   : 1 computes a - b (b inverted, carry-in forced to 1)
//   out_valid_o/out_ready_i : result handshake
//   sum_o, cout_o, ovf_o    : sum, carry-out (1 = no borrow when subtracting),
//                             two's-complement overflow
// Pipeline: stage G register, NP prefix register stages (each covering up to
// LEVELS_PER_STAGE levels), then the output register; latency NP + 2 cycles.
// Every register, valid bits included, loads only when the pipeline advances.
module pipelined_prefix_adder
    import pa_pkg::*;
#(
    parameter int unsigned DATA_WIDTH       = 8,
    parameter int unsigned LEVELS_PER_STAGE = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    input  logic                  cin_i,
    input  logic                  sub_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] sum_o,
    output logic                  cout_o,
    output logic                  ovf_o
);

    localparam int unsigned L  = clog2(DATA_WIDTH);
    localparam int unsigned NP = num_stages(DATA_WIDTH, LEVELS_PER_STAGE);

    logic adv;

    // Stage G
    gp_t  [DATA_WIDTH-1:0] gp0_q, gp0_d;
    logic [DATA_WIDTH-1:0] p0_q, p0_d;
    logic                  c0_q, c0_d;
    logic                  vld0_q, vld0_d;

    // Prefix register stages; index s holds the result of prefix stage s
    gp_t  [DATA_WIDTH-1:0] pf_gp_q  [NP];
    gp_t  [DATA_WIDTH-1:0] pf_gp_d  [NP];
    logic [DATA_WIDTH-1:0] pf_p_q   [NP];
    logic [DATA_WIDTH-1:0] pf_p_d   [NP];
    logic                  pf_c0_q  [NP];
    logic                  pf_c0_d  [NP];
    logic                  pf_vld_q [NP];
    logic                  pf_vld_d [NP];

    // Output stage
    logic [DATA_WIDTH-1:0] sum_q, sum_d;
    logic                  cout_q, cout_d;
    logic                  ovf_q, ovf_d;
    logic                  out_valid_q, out_valid_d;

    // Prefix network wiring
    gp_t  [DATA_WIDTH-1:0] gp_fold;
    gp_t  [DATA_WIDTH-1:0] lvl_in  [L];
    gp_t  [DATA_WIDTH-1:0] lvl_out [L];
    logic [DATA_WIDTH-1:0] carry;
    logic [DATA_WIDTH-1:0] b_eff;

    // The pipeline moves whenever the output register is empty or being drained.
    assign adv        = ~out_valid_q | out_ready_i;
    assign in_ready_o = adv;

    // ---------------------------------------------------------------------
    // Stage G: bitwise generate/propagate from the (possibly inverted) operands
    // ---------------------------------------------------------------------
    always_comb begin
        b_eff  = sub_i ? ~b_i : b_i;
        gp0_d  = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            gp0_d[i].g = a_i[i] & b_eff[i];
            gp0_d[i].p = a_i[i] ^ b_eff[i];
        end
        p0_d   = a_i ^ b_eff;
        c0_d   = sub_i | cin_i;
        vld0_d = in_valid_i;
    end

    // Fold the carry-in in as bit -1 so the tree yields true carries C[i].
    always_comb begin
        gp_fold      = gp0_q;
        gp_fold[0].g = gp0_q[0].g | (gp0_q[0].p & c0_q);
    end

    // ---------------------------------------------------------------------
    // Prefix levels; a register boundary follows every LEVELS_PER_STAGE levels
    // ---------------------------------------------------------------------
    for (genvar k = 0; k < L; k++) begin : g_level
        if (k == 0) begin : g_src_fold
            assign lvl_in[k] = gp_fold;
        end else if ((k % LEVELS_PER_STAGE) == 0) begin : g_src_reg
            assign lvl_in[k] = pf_gp_q[k / LEVELS_PER_STAGE - 1];
        end else begin : g_src_comb
            assign lvl_in[k] = lvl_out[k - 1];
        end

        prefix_level #(
            .DATA_WIDTH (DATA_WIDTH),
            .DIST       (2 ** k)
        ) u_level (
            .gp_i (lvl_in[k]),
            .gp_o (lvl_out[k])
        );
    end

    for (genvar s = 0; s < NP; s++) begin : g_stage
        // Last level feeding this register; the final stage may be short.
        localparam int unsigned LastLvl =
            ((s + 1) * LEVELS_PER_STAGE < L) ? (s + 1) * LEVELS_PER_STAGE - 1 : L - 1;

        assign pf_gp_d[s] = lvl_out[LastLvl];

        if (s == 0) begin : g_first
            assign pf_p_d[s]   = p0_q;
            assign pf_c0_d[s]  = c0_q;
            assign pf_vld_d[s] = vld0_q;
        end else begin : g_rest
            assign pf_p_d[s]   = pf_p_q[s - 1];
            assign pf_c0_d[s]  = pf_c0_q[s - 1];
            assign pf_vld_d[s] = pf_vld_q[s - 1];
        end
    end

    // ---------------------------------------------------------------------
    // Output stage: sum from bitwise propagate and the carry into each bit
    // ---------------------------------------------------------------------
    always_comb begin
        carry = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            carry[i] = pf_gp_q[NP-1][i].g;
        end
        sum_d       = pf_p_q[NP-1] ^ {carry[DATA_WIDTH-2:0], pf_c0_q[NP-1]};
        cout_d      = carry[DATA_WIDTH-1];
        ovf_d       = carry[DATA_WIDTH-1] ^ carry[DATA_WIDTH-2];
        out_valid_d = pf_vld_q[NP-1];
    end

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gp0_q  <= '0;
            p0_q   <= '0;
            c0_q   <= 1'b0;
            vld0_q <= 1'b0;
            for (int unsigned s = 0; s < NP; s++) begin
                pf_gp_q[s]  <= '0;
                pf_p_q[s]   <= '0;
                pf_c0_q[s]  <= 1'b0;
                pf_vld_q[s] <= 1'b0;
            end
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (adv) begin
            gp0_q  <= gp0_d;
            p0_q   <= p0_d;
            c0_q   <= c0_d;
            vld0_q <= vld0_d;
            for (int unsigned s = 0; s < NP; s++) begin
                pf_gp_q[s]  <= pf_gp_d[s];
                pf_p_q[s]   <= pf_p_d[s];
                pf_c0_q[s]  <= pf_c0_d[s];
                pf_vld_q[s] <= pf_vld_d[s];
            end
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign sum_o       = sum_q;
    assign cout_o      = cout_q;
    assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_pipelined_prefix_adder.sv
// Self-checking bench: an 8-bit default instance and a 12-bit, 2-levels-per-stage
// instance. Expected results are queued on each accepted beat and compared as
// results appear at the output.
module tb_pipelined_prefix_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic       v8, r8, cin8, sub8, ov8, ordy8, co8, of8;
    logic [7:0] a8, b8, s8;

    logic        v12, r12, cin12, sub12, ov12, ordy12, co12, of12;
    logic [11:0] a12, b12, s12;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [17:0] q8[$];
    logic [17:0] q12[$];
    int          qc8[$];
    int          qc12[$];
    logic [17:0] nxt8, nxt12;
    bit          lat_chk, stall8, stall12, acc8, acc12;

    pipelined_prefix_adder #(
        .DATA_WIDTH       (8),
        .LEVELS_PER_STAGE (1)
    ) u_dut8 (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (v8),
        .in_ready_o  (r8),
        .a_i         (a8),
        .b_i         (b8),
        .cin_i       (cin8),
        .sub_i       (sub8),
        .out_valid_o (ov8),
        .out_ready_i (ordy8),
        .sum_o       (s8),
        .cout_o      (co8),
        .ovf_o       (of8)
    );

    pipelined_prefix_adder #(
        .DATA_WIDTH       (12),
        .LEVELS_PER_STAGE (2)
    ) u_dut12 (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (v12),
        .in_ready_o  (r12),
        .a_i         (a12),
        .b_i         (b12),
        .cin_i       (cin12),
        .sub_i       (sub12),
        .out_valid_o (ov12),
        .out_ready_i (ordy12),
        .sum_o       (s12),
        .cout_o      (co12),
        .ovf_o       (of12)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer add of a, effective b and carry-in; returns {ovf, cout, sum}.
    function automatic logic [17:0] ref_add(input int w, input logic [15:0] a,
                                            input logic [15:0] b, input logic cin,
                                            input logic sub);
        logic [31:0] m, be, full, s;
        logic        co, ov;
        m    = (32'd1 << w) - 32'd1;
        be   = sub ? (~{16'h0, b} & m) : {16'h0, b};
        full = {16'h0, a} + be + {31'h0, sub | cin};
        s    = full & m;
        co   = full[w];
        ov   = (a[w-1] == be[w-1]) && (s[w-1] != a[w-1]);
        return {ov, co, s[15:0]};
    endfunction

    // One clock: observe at the falling edge, then return 1 time unit after the rising edge.
    task automatic cycle();
        @(negedge clk);
        if (stall8) chk("stall_hold_valid8", {31'h0, ov8}, 32'd1);
        if (ov8) begin
            if (q8.size() == 0) begin
                chk("spurious_out8", {31'h0, ov8}, 32'd0);
            end else begin
                chk("result8", {14'h0, of8, co8, 8'h00, s8}, {14'h0, q8[0]});
                if (ordy8) begin
                    if (lat_chk) chk("latency8", cyc - qc8[0], 32'd5);
                    void'(q8.pop_front());
                    void'(qc8.pop_front());
                end
            end
        end
        stall8 = ov8 & ~ordy8;
        if (stall8) chk("in_ready_stall8", {31'h0, r8}, 32'd0);
        acc8 = v8 & r8;
        if (acc8) begin
            q8.push_back(nxt8);
            qc8.push_back(cyc);
        end

        if (stall12) chk("stall_hold_valid12", {31'h0, ov12}, 32'd1);
        if (ov12) begin
            if (q12.size() == 0) begin
                chk("spurious_out12", {31'h0, ov12}, 32'd0);
            end else begin
                chk("result12", {14'h0, of12, co12, 4'h0, s12}, {14'h0, q12[0]});
                if (ordy12) begin
                    if (lat_chk) chk("latency12", cyc - qc12[0], 32'd4);
                    void'(q12.pop_front());
                    void'(qc12.pop_front());
                end
            end
        end
        stall12 = ov12 & ~ordy12;
        if (stall12) chk("in_ready_stall12", {31'h0, r12}, 32'd0);
        acc12 = v12 & r12;
        if (acc12) begin
            q12.push_back(nxt12);
            qc12.push_back(cyc);
        end

        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                         input logic sub, input logic [17:0] exp);
        a8 = a; b8 = b; cin8 = cin; sub8 = sub; nxt8 = exp; v8 = 1'b1;
        for (int i = 0; i < 50; i++) begin
            cycle();
            if (acc8) break;
        end
        v8 = 1'b0;
        chk("accept8", {31'h0, acc8}, 32'd1);
    endtask

    task automatic send12(input logic [11:0] a, input logic [11:0] b, input logic cin,
                          input logic sub, input logic [17:0] exp);
        a12 = a; b12 = b; cin12 = cin; sub12 = sub; nxt12 = exp; v12 = 1'b1;
        for (int i = 0; i < 50; i++) begin
            cycle();
            if (acc12) break;
        end
        v12 = 1'b0;
        chk("accept12", {31'h0, acc12}, 32'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            if (q8.size() == 0 && q12.size() == 0) break;
            cycle();
        end
        chk("drain8", q8.size(), 32'd0);
        chk("drain12", q12.size(), 32'd0);
    endtask

    task automatic rand8();
        a8 = 8'($urandom); b8 = 8'($urandom);
        cin8 = 1'($urandom_range(0, 1)); sub8 = 1'($urandom_range(0, 1));
        nxt8 = ref_add(8, {8'h0, a8}, {8'h0, b8}, cin8, sub8);
    endtask

    task automatic rand12();
        a12 = 12'($urandom); b12 = 12'($urandom);
        cin12 = 1'($urandom_range(0, 1)); sub12 = 1'($urandom_range(0, 1));
        nxt12 = ref_add(12, {4'h0, a12}, {4'h0, b12}, cin12, sub12);
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        v8 = 0; a8 = 0; b8 = 0; cin8 = 0; sub8 = 0; ordy8 = 1;
        v12 = 0; a12 = 0; b12 = 0; cin12 = 0; sub12 = 0; ordy12 = 1;
        nxt8 = '0; nxt12 = '0;
        lat_chk = 1; stall8 = 0; stall12 = 0; acc8 = 0; acc12 = 0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid8", {31'h0, ov8}, 32'd0);
        chk("reset_in_ready8", {31'h0, r8}, 32'd1);
        chk("reset_outs8", {22'h0, of8, co8, s8}, 32'd0);
        chk("reset_out_valid12", {31'h0, ov12}, 32'd0);
        chk("reset_in_ready12", {31'h0, r12}, 32'd1);
        rst_n = 1'b1;
        cycle();

        // Directed 8-bit: signed overflow, wrap with carry-out, carry-in only
        send8(8'h7F, 8'h01, 1'b0, 1'b0, {1'b1, 1'b0, 16'h0080});
        drain();
        send8(8'hFF, 8'h01, 1'b0, 1'b0, {1'b0, 1'b1, 16'h0000});
        send8(8'h00, 8'h00, 1'b1, 1'b0, {1'b0, 1'b0, 16'h0001});
        drain();
        // Subtraction, with carry-in ignored on the last beat
        send8(8'h05, 8'h07, 1'b0, 1'b1, {1'b0, 1'b0, 16'h00FE});
        send8(8'h80, 8'h01, 1'b0, 1'b1, {1'b1, 1'b1, 16'h007F});
        send8(8'h05, 8'h07, 1'b1, 1'b1, {1'b0, 1'b0, 16'h00FE});
        drain();

        // Directed 12-bit: full-width carry ripple
        send12(12'hFFF, 12'h001, 1'b0, 1'b0, {1'b0, 1'b1, 16'h0000});
        drain();
        lat_chk = 0;

        // Stream of 20 random beats with random backpressure
        n = 0;
        rand8();
        for (int c = 0; c < 1000 && n < 20; c++) begin
            v8 = 1'b1;
            ordy8 = 1'($urandom_range(0, 1));
            cycle();
            if (acc8) begin
                n++;
                rand8();
            end
        end
        v8 = 1'b0;
        ordy8 = 1'b1;
        chk("stream8_count", n, 32'd20);
        drain();

        // Reset with four beats in flight
        for (int i = 0; i < 4; i++) begin
            rand8();
            send8(a8, b8, cin8, sub8, nxt8);
        end
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid8", {31'h0, ov8}, 32'd0);
        chk("midrst_in_ready8", {31'h0, r8}, 32'd1);
        q8.delete();
        qc8.delete();
        stall8 = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycle();
            chk("post_reset_idle8", {31'h0, ov8}, 32'd0);
        end

        // 12-bit random run with bubbles and backpressure
        n = 0;
        for (int c = 0; c < 60000 && n < 10000; c++) begin
            rand12();
            v12 = ($urandom_range(0, 3) != 0);
            ordy12 = ($urandom_range(0, 3) != 0);
            cycle();
            if (acc12) n++;
        end
        v12 = 1'b0;
        ordy12 = 1'b1;
        chk("stream12_count", n, 32'd10000);
        drain();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
